pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 6 +
 rtl/mem_wait_timer.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 79 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller and pipeline gates.
package pipe_pkg;
    localparam int REG_IDX_W = 5;
    localparam logic [31:0] NOP_INST = 32'h00000013;
    typedef enum logic {ST_RUN, ST_MEM_WAIT} hz_state_e;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles of a frozen memory access and flags the final permitted cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic hold,
    output logic expired
);
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    logic [CW-1:0] wait_cnt;
    always_ff @(posedge clk)
        wait_cnt <= !rst_n ? '0 : start ? CW'(1) : hold ? wait_cnt + 1'b1 : '0;
    assign expired = wait_cnt == CW'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for load-use, branch redirect and memory-wait hazards.
// Define PIPE_HAZARD_PERF_EN to add saturating stall/flush/timeout counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef PIPE_HAZARD_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    input  logic                 ex_br_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_en,
    output logic                 mem_wb_bubble,
    output logic                 mem_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [CNT_W-1:0]     timeout_cnt
`endif
);
    hz_state_e state, state_nxt;
    logic in_wait, start, hold, expired, timeout, frozen, hazard, br, lu;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .hold   (hold),
        .expired(expired)
    );

    always_ff @(posedge clk)
        state <= !rst_n ? ST_RUN : state_nxt;

    // A taken branch seen while frozen simply waits: br/lu are only honoured once unfrozen.
    always_comb begin
        in_wait       = state == ST_MEM_WAIT;
        hazard        = ex_is_load && ex_rd != '0 &&
                        (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
        start         = !in_wait && mem_req && !mem_ready;
        hold          = in_wait && !mem_ready && !expired;
        timeout       = in_wait && !mem_ready && expired;
        frozen        = start || hold;
        br            = !frozen && ex_br_taken;
        lu            = !frozen && !ex_br_taken && hazard;
        state_nxt     = frozen ? ST_MEM_WAIT : ST_RUN;
        pc_en         = rst_n && !frozen && !lu;
        if_id_en      = rst_n && !frozen && !lu;
        if_id_flush   = !rst_n || br;
        id_ex_en      = rst_n && !frozen;
        id_ex_flush   = !rst_n || br || lu;
        ex_mem_en     = rst_n && !frozen;
        mem_wb_bubble = !rst_n || frozen || timeout;
        mem_err       = rst_n && timeout;
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        stall_cnt   <= !rst_n ? '0 : (!pc_en && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
        flush_cnt   <= !rst_n ? '0 : (br && flush_cnt != '1) ? flush_cnt + 1'b1 : flush_cnt;
        timeout_cnt <= !rst_n ? '0 : (mem_err && timeout_cnt != '1) ? timeout_cnt + 1'b1 : timeout_cnt;
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (default build).
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs2, ex_is_load, ex_br_taken, mem_req, mem_ready;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    // Output vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err
    localparam logic [7:0] RST  = 8'b0010_1010;
    localparam logic [7:0] NORM = 8'b1101_0100;
    localparam logic [7:0] LU   = 8'b0001_1100;
    localparam logic [7:0] BR   = 8'b1111_1100;
    localparam logic [7:0] FRZ  = 8'b0000_0010;
    localparam logic [7:0] TOUT = 8'b1101_0111;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_br_taken  (ex_br_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_bubble(mem_wb_bubble),
        .mem_err      (mem_err)
    );

    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2, input logic u,
                        input logic [4:0] rd, input logic ld, input logic b, input logic mq,
                        input logic mr, input logic [7:0] exp_v, input string tag);
        logic [7:0] got, want;
        rst_n = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u;
        ex_rd = rd; ex_is_load = ld; ex_br_taken = b; mem_req = mq; mem_ready = mr;
        exp_q.push_back(exp_v);
        @(negedge clk);
        got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err};
        want = exp_q.pop_front();
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %b expected %b", tag, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        for (int i = 0; i < 3; i++) step(0, 5'd5, 5'd3, 1, 5'd5, 1, 1, 1, 0, RST, "reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "post_reset");
        step(1, 5'd5, 5'd9, 0, 5'd5, 1, 0, 0, 0, LU, "lu_rs1");
        step(1, 5'd5, 5'd9, 0, 5'd2, 0, 0, 0, 0, NORM, "lu_one_bubble");
        step(1, 5'd0, 5'd9, 0, 5'd0, 1, 0, 0, 0, NORM, "lu_x0");
        step(1, 5'd1, 5'd7, 0, 5'd7, 1, 0, 0, 0, NORM, "lu_rs2_unused");
        step(1, 5'd1, 5'd7, 1, 5'd7, 1, 0, 0, 0, LU, "lu_rs2_used");
        step(1, 5'd1, 5'd3, 1, 5'd3, 1, 1, 0, 0, BR, "br_over_lu");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "after_br");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, NORM, "mem_ready_now");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "mem_wait");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, NORM, "mem_release");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "after_release");
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "to_freeze");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, TOUT, "timeout");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "after_timeout");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "brf_enter");
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, FRZ, "brf_hold1");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, "brf_hold2");
        step(1, 0, 0, 0, 0, 0, 1, 0, 1, BR, "brf_release");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "luf_enter");
        step(1, 5'd4, 0, 0, 5'd4, 1, 0, 1, 1, LU, "luf_release");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "rstw_enter");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "rstw_hold");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, RST, "rstw_reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "rstw_run");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
